// File: rtl/deep_fp_engine.sv
// deep_fp_engine: two-layer fully-connected forward pass (ReLU hidden layer,
// linear output layer), one MAC per cycle, followed by a serial argmax and a
// label compare. Optional build macro DEEP_ACC_STATS_EN adds running
// total/correct counters with a clear input.
module deep_fp_engine #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 128,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int FRAC   = 9,
  parameter int PIX_W  = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [7:0]                                   label_in,
  input  logic                                         px_valid,
  input  logic [PIX_W-1:0]                             px_data,
  output logic                                         px_ready,
  input  logic                                         w_valid,
  input  logic [DATA_W-1:0]                            w_data,
  output logic                                         w_ready,
  output logic [$clog2(N_IN*N_HID+N_HID*N_OUT)-1:0]    w_addr,
  output logic [N_OUT*DATA_W-1:0]                      result,
  output logic [7:0]                                   pred,
  output logic                                         correct,
  output logic                                         busy,
  output logic                                         done
`ifdef DEEP_ACC_STATS_EN
  ,
  input  logic                                         stat_clr,
  output logic [31:0]                                  stat_total,
  output logic [31:0]                                  stat_correct
`endif
);

  localparam int AW    = $clog2(N_IN*N_HID+N_HID*N_OUT);
  localparam int ACC_W = DATA_W + 8;
  localparam int SW    = 2*DATA_W + 1;
  localparam int PW    = PIX_W + DATA_W;
  localparam int NMAX  = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                        : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int CNT_W = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HW    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0]     SMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     SMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [PW-1:0]            PMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_L0, S_L1, S_ARGMAX, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           ic_q, ic_d, oc_q, oc_d;   // inner / outer loop counters
  logic [AW-1:0]              w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   x_q [N_IN],  x_d [N_IN];
  logic signed [DATA_W-1:0]   h_q [N_HID], h_d [N_HID];
  logic signed [DATA_W-1:0]   y_q [N_OUT], y_d [N_OUT]; // working outputs, published at argmax end
  logic signed [DATA_W-1:0]   best_q, best_d;
  logic [7:0]                 best_idx_q, best_idx_d, label_q, label_d, pred_q, pred_d;
  logic                       correct_q, correct_d;
  logic [N_OUT*DATA_W-1:0]    result_q, result_d;

  logic [PW-1:0]              pix_wide;
  logic signed [DATA_W-1:0]   pix_fx, mac_a, sat_v, relu_v, am_cur, nb_val;
  logic signed [2*DATA_W-1:0] prod, prod_sh;
  logic signed [SW-1:0]       sum;
  logic [7:0]                 nb_idx;
  logic                       am_take, last_i, last_h, last_o, last_j, last_k;

  // Datapath: pixel scaling, MAC with floor shift, saturation, ReLU, argmax step
  always_comb begin
    pix_wide = PW'(px_data) << FRAC;
    pix_fx   = (pix_wide > PMAX) ? DMAX : pix_wide[DATA_W-1:0];
    mac_a    = (state_q == S_L1) ? h_q[ic_q[HW-1:0]] : x_q[ic_q[IW-1:0]];
    prod     = (2*DATA_W)'(mac_a) * (2*DATA_W)'($signed(w_data));
    prod_sh  = prod >>> FRAC;
    sum      = SW'(acc_q) + SW'(prod_sh);
    if (sum > SMAX)      sat_v = DMAX;
    else if (sum < SMIN) sat_v = DMIN;
    else                 sat_v = sum[DATA_W-1:0];
    relu_v   = sat_v[DATA_W-1] ? '0 : sat_v;
    am_cur   = y_q[ic_q[OW-1:0]];
    am_take  = (ic_q == '0) || (am_cur > best_q);
    nb_val   = am_take ? am_cur : best_q;
    nb_idx   = am_take ? 8'(ic_q) : best_idx_q;
    last_i   = (ic_q == CNT_W'(N_IN-1));
    last_h   = (ic_q == CNT_W'(N_HID-1));
    last_o   = (ic_q == CNT_W'(N_OUT-1));
    last_j   = (oc_q == CNT_W'(N_HID-1));
    last_k   = (oc_q == CNT_W'(N_OUT-1));
  end

  // Next-state and register updates for load, both MAC layers and argmax
  always_comb begin
    state_d    = state_q;
    ic_d       = ic_q;
    oc_d       = oc_q;
    w_addr_d   = w_addr_q;
    acc_d      = acc_q;
    x_d        = x_q;
    h_d        = h_q;
    y_d        = y_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    label_d    = label_q;
    pred_d     = pred_q;
    correct_d  = correct_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_LOAD;
        label_d  = label_in;
        ic_d     = '0;
        oc_d     = '0;
        acc_d    = '0;
        w_addr_d = '0;
      end
      S_LOAD: if (px_valid) begin
        x_d[ic_q[IW-1:0]] = pix_fx;
        if (last_i) begin
          ic_d    = '0;
          state_d = S_L0;
        end else ic_d = ic_q + CNT_W'(1);
      end
      S_L0: if (w_valid) begin
        w_addr_d = w_addr_q + AW'(1);
        if (last_i) begin
          h_d[oc_q[HW-1:0]] = relu_v;
          acc_d = '0;
          ic_d  = '0;
          if (last_j) begin
            oc_d    = '0;
            state_d = S_L1;
          end else oc_d = oc_q + CNT_W'(1);
        end else begin
          acc_d = sum[ACC_W-1:0];
          ic_d  = ic_q + CNT_W'(1);
        end
      end
      S_L1: if (w_valid) begin
        w_addr_d = w_addr_q + AW'(1);
        if (last_h) begin
          y_d[oc_q[OW-1:0]] = sat_v;
          acc_d = '0;
          ic_d  = '0;
          if (last_k) begin
            oc_d    = '0;
            state_d = S_ARGMAX;
          end else oc_d = oc_q + CNT_W'(1);
        end else begin
          acc_d = sum[ACC_W-1:0];
          ic_d  = ic_q + CNT_W'(1);
        end
      end
      S_ARGMAX: begin
        best_d     = nb_val;
        best_idx_d = nb_idx;
        if (last_o) begin
          ic_d      = '0;
          pred_d    = nb_idx;
          correct_d = ({1'b0, nb_idx} == {1'b0, label_q}) && ({1'b0, label_q} < 9'(N_OUT));
          for (int k = 0; k < N_OUT; k++) result_d[k*DATA_W +: DATA_W] = y_q[k];
          state_d   = S_DONE;
        end else ic_d = ic_q + CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any image in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ic_q       <= '0;
      oc_q       <= '0;
      w_addr_q   <= '0;
      acc_q      <= '0;
      x_q        <= '{default: '0};
      h_q        <= '{default: '0};
      y_q        <= '{default: '0};
      best_q     <= '0;
      best_idx_q <= '0;
      label_q    <= '0;
      pred_q     <= '0;
      correct_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      oc_q       <= oc_d;
      w_addr_q   <= w_addr_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      h_q        <= h_d;
      y_q        <= y_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      label_q    <= label_d;
      pred_q     <= pred_d;
      correct_q  <= correct_d;
      result_q   <= result_d;
    end
  end

  assign px_ready = (state_q == S_LOAD);
  assign w_ready  = (state_q == S_L0) || (state_q == S_L1);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign w_addr   = w_addr_q;
  assign result   = result_q;
  assign pred     = pred_q;
  assign correct  = correct_q;

`ifdef DEEP_ACC_STATS_EN
  logic [31:0] stat_total_q, stat_total_d, stat_correct_q, stat_correct_d;

  // Accuracy counters; clear takes priority over a same-cycle increment
  always_comb begin
    stat_total_d   = stat_total_q;
    stat_correct_d = stat_correct_q;
    if (stat_clr) begin
      stat_total_d   = '0;
      stat_correct_d = '0;
    end else if (done) begin
      stat_total_d = stat_total_q + 32'd1;
      if (correct_q) stat_correct_d = stat_correct_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q   <= '0;
      stat_correct_q <= '0;
    end else begin
      stat_total_q   <= stat_total_d;
      stat_correct_q <= stat_correct_d;
    end
  end

  assign stat_total   = stat_total_q;
  assign stat_correct = stat_correct_q;
`endif

endmodule

// File: tb/tb_deep_fp_engine.sv
// tb_deep_fp_engine: table-driven bench for deep_fp_engine at N_IN=4,
// N_HID=2, N_OUT=3, DATA_W=16, FRAC=8. Expected results are queued when an
// image starts and popped when done fires.
module tb_deep_fp_engine;
  localparam int N_IN = 4, N_HID = 2, N_OUT = 3, DATA_W = 16, FRAC = 8, PIX_W = 8;

  logic        clk, rst, start;
  logic [7:0]  label_in;
  logic        px_valid, px_ready, w_valid, w_ready, correct, busy, done;
  logic [7:0]  px_data, pred;
  logic [15:0] w_data;
  logic [3:0]  w_addr;
  logic [47:0] result;
`ifdef DEEP_ACC_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_total, stat_correct;
`endif

  deep_fp_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DATA_W(DATA_W),
                   .FRAC(FRAC), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .label_in(label_in),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .w_addr(w_addr),
    .result(result), .pred(pred), .correct(correct), .busy(busy), .done(done)
`ifdef DEEP_ACC_STATS_EN
    , .stat_clr(stat_clr), .stat_total(stat_total), .stat_correct(stat_correct)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0][7:0]  pix;
    logic [15:0]      w0;      // every L0 weight
    logic [2:0][15:0] w1;      // L1 weight per output row k
    logic [7:0]       label;
    logic             bp;      // toggle valids every cycle
    logic             ctl;     // pulse start mid-L0 and in DONE
    logic [47:0]      exp_res;
    logic [7:0]       exp_pred;
    logic             exp_cor;
  } vec_t;

  vec_t        vecs [9];
  vec_t        sb [$];
  logic [7:0]  pix_mem [4];
  logic [15:0] wmem [16];
  logic [1:0]  pidx;
  logic        bp;
  int          chk_cnt, pass_cnt;
  int          addr_err, hold_err, stall_seen;
  logic [3:0]  exp_addr, prev_addr;
  logic        prev_wv, prev_wr;
  logic [47:0] prev_res;

  always_comb px_data = pix_mem[pidx];
  always_comb w_data  = wmem[w_addr];

  // Valid generation: held high or toggling for backpressure
  always @(negedge clk) begin
    if (bp) begin
      px_valid = ~px_valid;
      w_valid  = ~w_valid;
    end else begin
      px_valid = 1'b1;
      w_valid  = 1'b1;
    end
  end

  // Pixel source pointer plus weight address sequence / stall-hold monitor
  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      pidx     <= '0;
      exp_addr <= '0;
    end else begin
      if (px_valid && px_ready) pidx <= pidx + 2'd1;
      if (w_valid && w_ready) begin
        if (w_addr != exp_addr) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 4'd1;
      end
    end
    if (prev_wr && !prev_wv && w_ready) begin
      stall_seen <= stall_seen + 1;
      if (w_addr != prev_addr) hold_err <= hold_err + 1;
    end
    prev_wr   <= w_ready;
    prev_wv   <= w_valid;
    prev_addr <= w_addr;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic load_mems(input vec_t v);
    for (int i = 0; i < 4; i++) pix_mem[i] = v.pix[i];
    for (int a = 0; a < 16; a++) wmem[a] = 16'h0;
    for (int a = 0; a < 8; a++) wmem[a] = v.w0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 2; j++) wmem[8 + k*2 + j] = v.w1[k];
  endtask

  task automatic run(input int id, input vec_t v);
    vec_t e;
    int   cyc;
    load_mems(v);
    label_in = v.label;
    bp = v.bp;
    @(negedge clk) start = 1'b1;
    sb.push_back(v);
    @(negedge clk) start = 1'b0;
    label_in = 8'd7;   // label must already be latched
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == 20) chk($sformatf("v%0d_hold", id), result, prev_res);
      start = (v.ctl && cyc == 8);
      @(negedge clk) cyc++;
    end
    start = 1'b0;
    if (!done) begin
      chk($sformatf("v%0d_timeout", id), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_res", id), result, e.exp_res);
      chk($sformatf("v%0d_pred", id), pred, e.exp_pred);
      chk($sformatf("v%0d_cor", id), correct, e.exp_cor);
      if (e.bp) chk($sformatf("v%0d_lat_delayed", id), cyc > 22, 1);
      else      chk($sformatf("v%0d_lat", id), cyc, 22);
      if (e.ctl) start = 1'b1;   // start during DONE must be ignored
      @(negedge clk) start = 1'b0;
      chk($sformatf("v%0d_done_pulse", id), done, 0);
      chk($sformatf("v%0d_idle", id), busy, 0);
      prev_res = e.exp_res;
    end
    bp = 1'b0;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; addr_err = 0; hold_err = 0; stall_seen = 0;
    rst = 1'b1; start = 1'b0; label_in = 8'd0; bp = 1'b0;
    px_valid = 1'b1; w_valid = 1'b1; prev_res = '0;
    prev_wr = 1'b0; prev_wv = 1'b0; prev_addr = '0;
`ifdef DEEP_ACC_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) pix_mem[i] = 8'd0;
    for (int a = 0; a < 16; a++) wmem[a] = 16'h0;

    //              pix                        w0       w1 {k2,k1,k0}                 lbl  bp ctl exp_res {k2,k1,k0}                   pred cor
    vecs[0] = '{{8'd1,8'd1,8'd1,8'd1},       16'h0100, {16'hFF00,16'h0100,16'h0080}, 8'd1, 0, 0, {16'hF800,16'h0800,16'h0400}, 8'd1, 1};
    vecs[1] = '{{8'd1,8'd1,8'd1,8'd1},       16'hFF00, {16'hFF00,16'h0100,16'h0080}, 8'd2, 0, 0, 48'h0,                        8'd0, 0};
    vecs[2] = '{{8'd100,8'd100,8'd100,8'd100},16'h0100,{16'h0100,16'h0100,16'h0100}, 8'd0, 0, 0, {16'h7FFF,16'h7FFF,16'h7FFF}, 8'd0, 1};
    vecs[3] = '{{8'd1,8'd1,8'd1,8'd1},       16'h0100, {16'hFF00,16'h0100,16'h0080}, 8'd1, 1, 0, {16'hF800,16'h0800,16'h0400}, 8'd1, 1};
    vecs[4] = '{{8'd1,8'd1,8'd1,8'd1},       16'h0100, {16'hFF00,16'h0100,16'h0080}, 8'd1, 0, 1, {16'hF800,16'h0800,16'h0400}, 8'd1, 1};
    vecs[5] = '{{8'd0,8'd0,8'd0,8'd200},     16'h0100, {16'h0080,16'h0080,16'h0080}, 8'd0, 0, 0, {16'h7FFE,16'h7FFE,16'h7FFE}, 8'd0, 1};
    vecs[6] = '{{8'd0,8'd0,8'd0,8'd1},       16'h0001, {16'hFF80,16'h0080,16'h0100}, 8'd0, 0, 0, {16'hFFFE,16'h0000,16'h0002}, 8'd0, 1};
    vecs[7] = '{{8'd1,8'd1,8'd1,8'd1},       16'h0100, {16'hFF00,16'h0000,16'hFF00}, 8'd5, 0, 0, {16'hF800,16'h0000,16'hF800}, 8'd1, 0};
    vecs[8] = '{{8'd1,8'd1,8'd1,8'd1},       16'h0100, {16'h0100,16'h0100,16'h0000}, 8'd0, 0, 0, {16'h0800,16'h0800,16'h0000}, 8'd1, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_px_ready", px_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_result", result, 0);
    chk("rst_pred", pred, 0);
    chk("rst_correct", correct, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run(i, vecs[i]);

    // Reset asserted during L1 aborts the image and clears outputs
    load_mems(vecs[0]);
    label_in = 8'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst_in_l1", w_ready && w_addr >= 4'd8, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_pred", pred, 0);
    chk("midrst_w_addr", w_addr, 0);
    chk("midrst_ready", {px_ready, w_ready}, 0);
    prev_res = '0;
    run(9, vecs[0]);

`ifdef DEEP_ACC_STATS_EN
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    begin
      vec_t v;
      v = vecs[0];
      run(10, v);
      v.label = 8'd0; v.exp_cor = 1'b0;
      run(11, v);
      run(12, vecs[0]);
    end
    chk("stat_total", stat_total, 3);
    chk("stat_correct", stat_correct, 2);
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    chk("stat_total_clr", stat_total, 0);
    chk("stat_correct_clr", stat_correct, 0);
`endif

    chk("addr_sequence_errs", addr_err, 0);
    chk("addr_hold_errs", hold_err, 0);
    chk("stall_observed", stall_seen > 0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
